// File: rtl/packet_read_sequencer_if.sv
// ---------------------------------------------------------------------------
// packet_read_sequencer_if
// Request, SRAM page-read and packet-stream signals of the packet read
// sequencer, bundled so that the sequencer and its environment connect
// through a single port.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface packet_read_sequencer_if;
   // packet read request
   logic        start_vld;
   logic        start_rdy;
   logic [11:0] start_head;
   logic [11:0] start_tail;
   logic [3:0]  start_last_len;
   // SRAM page read
   logic        rd_page_down;
   logic [3:0]  rd_sram_idx;
   logic [7:0]  rd_page;
   logic [11:0] rd_next_page;
   logic [15:0] rd_xfer_data;
   // packet stream towards the output port
   logic        out_vld;
   logic [15:0] out_data;
   logic        out_sop;
   logic        out_eop;
   logic        out_rdy;

   // the sequencer side
   modport master (
      input  start_vld, start_head, start_tail, start_last_len,
      output start_rdy,
      output rd_page_down, rd_sram_idx, rd_page,
      input  rd_next_page, rd_xfer_data,
      output out_vld, out_data, out_sop, out_eop,
      input  out_rdy
   );

   // the requester / SRAM / output-port side
   modport slave (
      output start_vld, start_head, start_tail, start_last_len,
      input  start_rdy,
      input  rd_page_down, rd_sram_idx, rd_page,
      output rd_next_page, rd_xfer_data,
      input  out_vld, out_data, out_sop, out_eop,
      output out_rdy
   );
endinterface

`default_nettype wire

// File: rtl/packet_read_sequencer.sv
// ---------------------------------------------------------------------------
// packet_read_sequencer
// Walks a packet's page chain through the SRAM jump tables: one page-read
// pulse per page, eight read beats per page, forwarding the packet's beats
// to the output port with start/end-of-packet marks. Pages are chained
// back-to-back while the output port is ready at a page boundary, and the
// walk is aborted with a chain-error pulse when the page limit is hit
// without reaching the tail.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module packet_read_sequencer #(
   parameter int MAX_PAGES = 32
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   packet_read_sequencer_if.master bus,
   output logic                    busy,
   output logic                    chain_err
);

   localparam int CNT_W = $clog2(MAX_PAGES + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_PAGE  = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [11:0]        r_cur_page;   // drives rd_sram_idx/rd_page, changes only on entry to ISSUE
   logic [11:0]        r_next_page;  // jump-table result for the page being read
   logic [11:0]        r_tail;
   logic [3:0]         r_last_len;   // normalised to 1..8
   logic [CNT_W-1:0]   r_page_cnt;   // pages pulsed so far in this packet
   logic [2:0]         r_beat_cnt;

   logic               r_out_vld;
   logic [15:0]        r_out_data;
   logic               r_out_sop;
   logic               r_out_eop;
   logic               r_chain_err;

   logic               w_accept;
   logic               w_is_last;
   logic               w_page_end;
   logic               w_overrun;
   logic               w_fwd;
   logic               w_sop;
   logic               w_eop;
   logic               w_load_next;
   logic [3:0]         w_len_norm;

   assign w_accept   = bus.start_vld && (r_state == S_IDLE);
   assign w_is_last  = (r_cur_page == r_tail);
   assign w_page_end = (r_state == S_PAGE) && (r_beat_cnt == 3'd7);
   assign w_overrun  = w_page_end && !w_is_last && (r_page_cnt == CNT_W'(MAX_PAGES));

   // all eight beats of a middle page go out; the last page stops at last_len
   assign w_fwd = (r_state == S_PAGE) &&
                  (!w_is_last || ({1'b0, r_beat_cnt} < r_last_len));
   assign w_sop = (r_beat_cnt == 3'd0) && (r_page_cnt == CNT_W'(1));
   assign w_eop = w_is_last && ({1'b0, r_beat_cnt} == (r_last_len - 4'd1));

   // a length of 0 or anything above 8 means a full page
   assign w_len_norm = ((bus.start_last_len == 4'd0) || (bus.start_last_len > 4'd8)) ?
                       4'd8 : bus.start_last_len;

   // moving on to a follow-on page (not the first page of a packet)
   assign w_load_next = (w_state_nxt == S_ISSUE) && (r_state != S_IDLE);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // next-state decode; out_rdy matters only at a page boundary or in WAIT
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_PAGE;
         S_PAGE: begin
            if (r_beat_cnt == 3'd7) begin
               if (w_is_last || w_overrun) w_state_nxt = S_IDLE;
               else if (bus.out_rdy)       w_state_nxt = S_ISSUE;
               else                        w_state_nxt = S_WAIT;
            end
         end
         S_WAIT:  if (bus.out_rdy) w_state_nxt = S_ISSUE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // packet context, page chaining and beat/page counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_page  <= '0;
         r_next_page <= '0;
         r_tail      <= '0;
         r_last_len  <= 4'd8;
         r_page_cnt  <= '0;
         r_beat_cnt  <= '0;
      end else begin
         if (w_accept) begin
            r_cur_page <= bus.start_head;
            r_tail     <= bus.start_tail;
            r_last_len <= w_len_norm;
            r_page_cnt <= '0;
         end else if (w_load_next) begin
            r_cur_page <= r_next_page;
         end

         if (r_state == S_ISSUE) begin
            r_page_cnt <= r_page_cnt + CNT_W'(1);
            r_beat_cnt <= '0;
         end else if (r_state == S_PAGE) begin
            r_beat_cnt <= r_beat_cnt + 3'd1;
         end

         // the jump table answers in the cycle after the page-read pulse
         if ((r_state == S_PAGE) && (r_beat_cnt == 3'd0))
            r_next_page <= bus.rd_next_page;
      end
   end

   // register forwarded beats onto the packet stream, plus the error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld   <= 1'b0;
         r_out_data  <= '0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
         r_chain_err <= 1'b0;
      end else begin
         r_out_vld   <= w_fwd;
         r_out_sop   <= w_fwd && w_sop;
         r_out_eop   <= w_fwd && w_eop;
         r_chain_err <= w_overrun;
         if (w_fwd) r_out_data <= bus.rd_xfer_data;
      end
   end

   assign bus.start_rdy    = (r_state == S_IDLE);
   assign bus.rd_page_down = (r_state == S_ISSUE);
   assign bus.rd_sram_idx  = r_cur_page[11:8];
   assign bus.rd_page      = r_cur_page[7:0];
   assign bus.out_vld      = r_out_vld;
   assign bus.out_data     = r_out_data;
   assign bus.out_sop      = r_out_sop;
   assign bus.out_eop      = r_out_eop;
   assign busy             = (r_state != S_IDLE);
   assign chain_err        = r_chain_err;

endmodule

`default_nettype wire

// File: tb/tb_packet_read_sequencer.sv
// ---------------------------------------------------------------------------
// tb_packet_read_sequencer
// Directed bench: an SRAM model answers page-read pulses with jump-table and
// beat data ({page, beat}), monitors log pulses and output beats, and each
// scenario is checked against hand-computed values.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_packet_read_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   logic chain_err;
   int   cyc = 0;

   packet_read_sequencer_if bus_if ();

   packet_read_sequencer #(.MAX_PAGES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_if.master),
      .busy      (busy),
      .chain_err (chain_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // SRAM model: jump table and beat data {page, beat index}
   logic [11:0] jt [0:4095];
   logic [11:0] sp = 12'h000;
   logic [3:0]  ph = 4'h0;
   always @(posedge clk) begin
      if (bus_if.rd_page_down) begin
         sp <= {bus_if.rd_sram_idx, bus_if.rd_page};
         ph <= 4'h0;
      end else begin
         ph <= ph + 4'h1;
      end
   end
   assign bus_if.rd_next_page = jt[sp];
   assign bus_if.rd_xfer_data = {sp, ph};

   // monitor logs
   int          pcyc[$];
   logic [11:0] ppg[$];
   logic [15:0] bdat[$];
   bit          bsop[$];
   bit          beop[$];
   int          bcyc[$];
   int          acc[$];
   int          errs = 0;
   bit          prev_err = 1'b0;
   logic        rdy_after_err = 1'b0;

   always @(negedge clk) begin
      if (bus_if.rd_page_down) begin
         pcyc.push_back(cyc);
         ppg.push_back({bus_if.rd_sram_idx, bus_if.rd_page});
      end
      if (bus_if.out_vld) begin
         bdat.push_back(bus_if.out_data);
         bsop.push_back(bus_if.out_sop);
         beop.push_back(bus_if.out_eop);
         bcyc.push_back(cyc);
      end
      if (bus_if.start_vld && bus_if.start_rdy) acc.push_back(cyc);
      if (prev_err) rdy_after_err = bus_if.start_rdy;
      if (chain_err) errs = errs + 1;
      prev_err = chain_err;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // safe accessors so a short log reads as a wrong value, not an error
   function automatic logic [31:0] bd(int i);
      return (i < bdat.size()) ? {16'h0, bdat[i]} : 32'hDEAD_BEEF;
   endfunction
   function automatic logic [31:0] bs(int i);
      return (i < bsop.size()) ? {31'h0, bsop[i]} : 32'hDEAD_BEEF;
   endfunction
   function automatic logic [31:0] be(int i);
      return (i < beop.size()) ? {31'h0, beop[i]} : 32'hDEAD_BEEF;
   endfunction
   function automatic logic [31:0] pg(int i);
      return (i < ppg.size()) ? {20'h0, ppg[i]} : 32'hDEAD_BEEF;
   endfunction
   function automatic int pgap(int i);
      return (i + 1 < pcyc.size()) ? pcyc[i+1] - pcyc[i] : -1000;
   endfunction
   function automatic int nsop();
      int n = 0;
      foreach (bsop[i]) n += int'(bsop[i]);
      return n;
   endfunction
   function automatic int neop();
      int n = 0;
      foreach (beop[i]) n += int'(beop[i]);
      return n;
   endfunction

   task automatic clear_mon();
      pcyc.delete(); ppg.delete(); bdat.delete(); bsop.delete();
      beop.delete(); bcyc.delete(); acc.delete();
      errs = 0;
      rdy_after_err = 1'b0;
   endtask

   // present one request; returns #1 into the ISSUE cycle
   task automatic start_pkt(input logic [11:0] head, input logic [11:0] tail, input logic [3:0] len);
      @(posedge clk); #1;
      bus_if.start_vld      = 1'b1;
      bus_if.start_head     = head;
      bus_if.start_tail     = tail;
      bus_if.start_last_len = len;
      @(posedge clk); #1;
      bus_if.start_vld      = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      check(tag, {31'h0, done}, 32'h1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rdy"},   {31'h0, bus_if.start_rdy},    32'h1);
      check({tag, "_pd"},    {31'h0, bus_if.rd_page_down}, 32'h0);
      check({tag, "_page"},  {20'h0, bus_if.rd_sram_idx, bus_if.rd_page}, 32'h0);
      check({tag, "_vld"},   {31'h0, bus_if.out_vld},      32'h0);
      check({tag, "_sopeop"}, {30'h0, bus_if.out_sop, bus_if.out_eop}, 32'h0);
      check({tag, "_data"},  {16'h0, bus_if.out_data},     32'h0);
      check({tag, "_busy"},  {31'h0, busy},                32'h0);
      check({tag, "_err"},   {31'h0, chain_err},           32'h0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) jt[i] = 12'h000;
      jt[12'h101] = 12'h2A0;
      jt[12'h2A0] = 12'h10F;
      jt[12'h700] = 12'h701;
      jt[12'h701] = 12'h700;

      rst_n                 = 1'b0;
      bus_if.start_vld      = 1'b0;
      bus_if.start_head     = 12'h000;
      bus_if.start_tail     = 12'h000;
      bus_if.start_last_len = 4'd0;
      bus_if.out_rdy        = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1;
      check_idle_outputs("rst");

      // single page, last_len 3
      clear_mon();
      start_pkt(12'h305, 12'h305, 4'd3);
      wait_idle("sp_idle");
      check("sp_npulse", pcyc.size(), 1);
      check("sp_page",   pg(0), 32'h305);
      check("sp_nbeats", bdat.size(), 3);
      check("sp_lat",    (bcyc.size() > 0 && pcyc.size() > 0) ? bcyc[0] - pcyc[0] : -1, 2);
      check("sp_d0",     bd(0), 32'h3050);
      check("sp_d2",     bd(2), 32'h3052);
      check("sp_sop0",   bs(0), 1);
      check("sp_eop2",   be(2), 1);
      check("sp_eop0",   be(0), 0);

      // last_len 0 and 12 both mean a full page
      clear_mon();
      start_pkt(12'h305, 12'h305, 4'd0);
      wait_idle("l0_idle");
      check("l0_nbeats", bdat.size(), 8);
      check("l0_eop7",   be(7), 1);
      clear_mon();
      start_pkt(12'h305, 12'h305, 4'd12);
      wait_idle("l12_idle");
      check("l12_nbeats", bdat.size(), 8);
      check("l12_d7",     bd(7), 32'h3057);
      check("l12_neop",   neop(), 1);

      // three-page chain, back-to-back
      clear_mon();
      start_pkt(12'h101, 12'h10F, 4'd8);
      wait_idle("ch_idle");
      check("ch_npulse", pcyc.size(), 3);
      check("ch_pg1",    pg(1), 32'h2A0);
      check("ch_pg2",    pg(2), 32'h10F);
      check("ch_gap0",   pgap(0), 9);
      check("ch_gap1",   pgap(1), 9);
      check("ch_nbeats", bdat.size(), 24);
      check("ch_d0",     bd(0), 32'h1010);
      check("ch_d8",     bd(8), 32'h2A00);
      check("ch_d23",    bd(23), 32'h10F7);
      check("ch_eop23",  be(23), 1);
      check("ch_nsop",   nsop(), 1);
      check("ch_neop",   neop(), 1);

      // same chain, output port stalls at the end of page 1
      clear_mon();
      bus_if.out_rdy = 1'b0;
      start_pkt(12'h101, 12'h10F, 4'd8);
      repeat (13) @(posedge clk);
      #1 bus_if.out_rdy = 1'b1;
      wait_idle("wt_idle");
      check("wt_npulse", pcyc.size(), 3);
      check("wt_gap0",   pgap(0), 14);
      check("wt_gap1",   pgap(1), 9);
      check("wt_nbeats", bdat.size(), 24);
      check("wt_d7",     bd(7), 32'h1017);
      check("wt_d8",     bd(8), 32'h2A00);
      check("wt_d23",    bd(23), 32'h10F7);
      check("wt_eop23",  be(23), 1);

      // jump table loops without reaching the tail (limit 4 pages)
      clear_mon();
      start_pkt(12'h700, 12'h7FF, 4'd8);
      wait_idle("lp_idle");
      check("lp_npulse", pcyc.size(), 4);
      check("lp_span",   (pcyc.size() == 4) ? pcyc[3] - pcyc[0] : -1, 27);
      check("lp_pg3",    pg(3), 32'h701);
      check("lp_errs",   errs, 1);
      check("lp_neop",   neop(), 0);
      check("lp_nbeats", bdat.size(), 32);
      check("lp_rdy",    {31'h0, rdy_after_err}, 1);

      // reset at beat 4 of page 2, then a fresh packet
      clear_mon();
      start_pkt(12'h101, 12'h10F, 4'd8);
      repeat (14) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("mr");
      check("mr_npulse", pcyc.size(), 2);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      start_pkt(12'h305, 12'h305, 4'd3);
      wait_idle("mr_idle");
      check("mr_nbeats", bdat.size(), 3);
      check("mr_page",   pg(0), 32'h305);
      check("mr_sop0",   bs(0), 1);
      check("mr_eop2",   be(2), 1);

      // request held while busy is taken only on the next IDLE cycle
      clear_mon();
      @(posedge clk); #1;
      bus_if.start_vld      = 1'b1;
      bus_if.start_head     = 12'h305;
      bus_if.start_tail     = 12'h305;
      bus_if.start_last_len = 4'd3;
      for (int i = 0; i < 50 && acc.size() < 1; i++) @(negedge clk);
      @(posedge clk); #1;
      bus_if.start_head     = 12'h2A0;
      bus_if.start_tail     = 12'h2A0;
      for (int i = 0; i < 50 && acc.size() < 2; i++) @(negedge clk);
      @(posedge clk); #1;
      bus_if.start_vld      = 1'b0;
      wait_idle("hd_idle");
      check("hd_nacc",   acc.size(), 2);
      check("hd_gap",    (acc.size() == 2) ? acc[1] - acc[0] : -1, 10);
      check("hd_npulse", pcyc.size(), 2);
      check("hd_pg0",    pg(0), 32'h305);
      check("hd_pg1",    pg(1), 32'h2A0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // overall watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
